// File: rtl/tap_param_ctrl.sv
// ---------------------------------------------------------------------------
// tap_param_ctrl
// Full 16-state IEEE 1149.1 TAP controller with a parametrised instruction
// register and three data registers: BYPASS (1 bit), IDCODE (32 bits) and a
// USER shift register whose updated value is presented in parallel.
//
// Ports:
//   GCLK_Pad      in   1         clock, everything changes on its rising edge
//   TRST_Pad      in   1         synchronous active-high reset
//   TMS_Pad       in   1         TAP mode select
//   TDI_Pad       in   1         serial data in
//   TDO_Pad       out  1         registered serial data out
//   state_obs_Pad out  4         current TAP state encoding
//   instr_Pad     out  IR_WIDTH  active instruction
//   user_dr_Pad   out  DR_WIDTH  USER register parallel output
//   user_upd_Pad  out  1         one-cycle pulse after user_dr_Pad updates
//
// Any opcode other than IDCODE_OP or USER_OP, including the all-ones
// BYPASS opcode, selects the BYPASS register.
// ---------------------------------------------------------------------------
module tap_param_ctrl #(
    parameter int                  IR_WIDTH   = 4,
    parameter int                  DR_WIDTH   = 8,
    parameter logic [31:0]         IDCODE_VAL = 32'h1A5C_0001,
    parameter logic [IR_WIDTH-1:0] IDCODE_OP  = IR_WIDTH'(4'b0001),
    parameter logic [IR_WIDTH-1:0] USER_OP    = IR_WIDTH'(4'b0010)
) (
    input  logic                GCLK_Pad,
    input  logic                TRST_Pad,
    input  logic                TMS_Pad,
    input  logic                TDI_Pad,
    output logic                TDO_Pad,
    output logic [3:0]          state_obs_Pad,
    output logic [IR_WIDTH-1:0] instr_Pad,
    output logic [DR_WIDTH-1:0] user_dr_Pad,
    output logic                user_upd_Pad
);

    typedef enum logic [3:0] {
        ST_TLR      = 4'hF,
        ST_RTI      = 4'hC,
        ST_SEL_DR   = 4'h7,
        ST_CAP_DR   = 4'h6,
        ST_SH_DR    = 4'h2,
        ST_EX1_DR   = 4'h1,
        ST_PAUSE_DR = 4'h3,
        ST_EX2_DR   = 4'h0,
        ST_UPD_DR   = 4'h5,
        ST_SEL_IR   = 4'h4,
        ST_CAP_IR   = 4'hE,
        ST_SH_IR    = 4'hA,
        ST_EX1_IR   = 4'h9,
        ST_PAUSE_IR = 4'hB,
        ST_EX2_IR   = 4'h8,
        ST_UPD_IR   = 4'hD
    } tap_state_t;

    typedef enum logic [1:0] {
        SEL_BYPASS,
        SEL_IDCODE,
        SEL_USER
    } dr_sel_t;

    // The IR always captures ...01 so a scan can verify the chain length.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    tap_state_t          state;
    tap_state_t          next_state;
    dr_sel_t             dr_sel;

    logic [IR_WIDTH-1:0] ir_sr;
    logic [31:0]         idcode_sr;
    logic [DR_WIDTH-1:0] user_sr;
    logic                bypass_sr;
    logic [IR_WIDTH-1:0] instr;
    logic [DR_WIDTH-1:0] user_dr;
    logic                user_upd;
    logic                tdo;

    logic [IR_WIDTH-1:0] ir_shift;
    logic [31:0]         idcode_shift;
    logic [DR_WIDTH-1:0] user_shift;

    // State register; reset dominates TMS.
    always_ff @(posedge GCLK_Pad) begin
        if (TRST_Pad) begin
            state <= ST_TLR;
        end else begin
            state <= next_state;
        end
    end

    // TAP next-state function driven by TMS.
    always_comb begin
        next_state = state;
        case (state)
            ST_TLR:      next_state = TMS_Pad ? ST_TLR    : ST_RTI;
            ST_RTI:      next_state = TMS_Pad ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR:   next_state = TMS_Pad ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR:   next_state = TMS_Pad ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:    next_state = TMS_Pad ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR:   next_state = TMS_Pad ? ST_UPD_DR : ST_PAUSE_DR;
            ST_PAUSE_DR: next_state = TMS_Pad ? ST_EX2_DR : ST_PAUSE_DR;
            ST_EX2_DR:   next_state = TMS_Pad ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR:   next_state = TMS_Pad ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR:   next_state = TMS_Pad ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR:   next_state = TMS_Pad ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:    next_state = TMS_Pad ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR:   next_state = TMS_Pad ? ST_UPD_IR : ST_PAUSE_IR;
            ST_PAUSE_IR: next_state = TMS_Pad ? ST_EX2_IR : ST_PAUSE_IR;
            ST_EX2_IR:   next_state = TMS_Pad ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR:   next_state = TMS_Pad ? ST_SEL_DR : ST_RTI;
            default:     next_state = ST_TLR;
        endcase
    end

    // Data register selection from the active instruction.
    always_comb begin
        dr_sel = SEL_BYPASS;
        if (instr == IDCODE_OP) begin
            dr_sel = SEL_IDCODE;
        end else if (instr == USER_OP) begin
            dr_sel = SEL_USER;
        end
    end

    // Right-shifted versions of each register with TDI entering the MSB;
    // written this way so a 1-bit register needs no special case.
    always_comb begin
        ir_shift                   = ir_sr >> 1;
        ir_shift[IR_WIDTH-1]       = TDI_Pad;
        idcode_shift               = idcode_sr >> 1;
        idcode_shift[31]           = TDI_Pad;
        user_shift                 = user_sr >> 1;
        user_shift[DR_WIDTH-1]     = TDI_Pad;
    end

    // Capture/shift/update actions happen on the edge spent in each state.
    // TDO only moves in the shift states, so it holds everywhere else.
    always_ff @(posedge GCLK_Pad) begin
        if (TRST_Pad) begin
            ir_sr     <= '0;
            idcode_sr <= '0;
            user_sr   <= '0;
            bypass_sr <= 1'b0;
            instr     <= IDCODE_OP;
            user_dr   <= '0;
            user_upd  <= 1'b0;
            tdo       <= 1'b0;
        end else begin
            user_upd <= 1'b0;
            case (state)
                ST_TLR: begin
                    instr <= IDCODE_OP;
                end
                ST_CAP_IR: begin
                    ir_sr <= IR_CAPTURE;
                end
                ST_SH_IR: begin
                    ir_sr <= ir_shift;
                    tdo   <= ir_sr[0];
                end
                ST_UPD_IR: begin
                    instr <= ir_sr;
                end
                ST_CAP_DR: begin
                    case (dr_sel)
                        SEL_IDCODE: idcode_sr <= IDCODE_VAL;
                        SEL_USER:   user_sr   <= user_dr;
                        default:    bypass_sr <= 1'b0;
                    endcase
                end
                ST_SH_DR: begin
                    case (dr_sel)
                        SEL_IDCODE: begin
                            idcode_sr <= idcode_shift;
                            tdo       <= idcode_sr[0];
                        end
                        SEL_USER: begin
                            user_sr <= user_shift;
                            tdo     <= user_sr[0];
                        end
                        default: begin
                            bypass_sr <= TDI_Pad;
                            tdo       <= bypass_sr;
                        end
                    endcase
                end
                ST_UPD_DR: begin
                    if (dr_sel == SEL_USER) begin
                        user_dr  <= user_sr;
                        user_upd <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign TDO_Pad       = tdo;
    assign state_obs_Pad = state;
    assign instr_Pad     = instr;
    assign user_dr_Pad   = user_dr;
    assign user_upd_Pad  = user_upd;

endmodule

// File: tb/tb_tap_param_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tap_param_ctrl
// Self-checking bench for tap_param_ctrl. A behavioural model (state table,
// bit queues for the scan chains) predicts every output after every edge;
// directed scans cover reset, IDCODE, IR load, USER write/readback, bypass
// and abort paths, then a randomized phase mixes scans, random TMS walks and
// resets.
// ---------------------------------------------------------------------------
module tb_tap_param_ctrl;

    localparam int          IRW     = 4;
    localparam int          DRW     = 8;
    localparam logic [31:0] IDV     = 32'h1A5C_0001;
    localparam logic [3:0]  OP_ID   = 4'b0001;
    localparam logic [3:0]  OP_USER = 4'b0010;

    logic           clk  = 1'b0;
    logic           trst = 1'b0;
    logic           tms  = 1'b0;
    logic           tdi  = 1'b0;
    logic           tdo;
    logic [3:0]     state_obs;
    logic [IRW-1:0] instr;
    logic [DRW-1:0] user_dr;
    logic           user_upd;

    always #5 clk = ~clk;

    tap_param_ctrl #(
        .IR_WIDTH  (IRW),
        .DR_WIDTH  (DRW),
        .IDCODE_VAL(IDV),
        .IDCODE_OP (OP_ID),
        .USER_OP   (OP_USER)
    ) dut (
        .GCLK_Pad     (clk),
        .TRST_Pad     (trst),
        .TMS_Pad      (tms),
        .TDI_Pad      (tdi),
        .TDO_Pad      (tdo),
        .state_obs_Pad(state_obs),
        .instr_Pad    (instr),
        .user_dr_Pad  (user_dr),
        .user_upd_Pad (user_upd)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int             m_state = 'hF;
    logic [IRW-1:0] m_instr = OP_ID;
    logic [DRW-1:0] m_user  = '0;
    bit             m_upd   = 1'b0;
    bit             m_tdo   = 1'b0;
    bit             ir_q[$];
    bit             dr_q[$];

    // TAP state graph as listed for the controller: {next on TMS=0, TMS=1}
    function automatic int tap_next(input int s, input bit t);
        case (s)
            'hF:     return t ? 'hF : 'hC;
            'hC:     return t ? 'h7 : 'hC;
            'h7:     return t ? 'h4 : 'h6;
            'h4:     return t ? 'hF : 'hE;
            'h6:     return t ? 'h1 : 'h2;
            'h2:     return t ? 'h1 : 'h2;
            'h1:     return t ? 'h5 : 'h3;
            'h3:     return t ? 'h0 : 'h3;
            'h0:     return t ? 'h5 : 'h2;
            'h5:     return t ? 'h7 : 'hC;
            'hE:     return t ? 'h9 : 'hA;
            'hA:     return t ? 'h9 : 'hA;
            'h9:     return t ? 'hD : 'hB;
            'hB:     return t ? 'h8 : 'hB;
            'h8:     return t ? 'hD : 'hA;
            'hD:     return t ? 'h7 : 'hC;
            default: return 'hF;
        endcase
    endfunction

    // Advance the model by one clock edge with the given inputs.
    task automatic model_edge(input bit r, input bit t, input bit d);
        if (r) begin
            m_state = 'hF;
            m_instr = OP_ID;
            m_user  = '0;
            m_upd   = 1'b0;
            m_tdo   = 1'b0;
            ir_q.delete();
            dr_q.delete();
            return;
        end
        m_upd = 1'b0;
        case (m_state)
            'hF: m_instr = OP_ID;
            'hE: begin
                ir_q.delete();
                for (int i = 0; i < IRW; i++) ir_q.push_back(i == 0);
            end
            'hA: begin
                m_tdo = ir_q.pop_front();
                ir_q.push_back(d);
            end
            'hD: for (int i = 0; i < IRW; i++) m_instr[i] = ir_q[i];
            'h6: begin
                dr_q.delete();
                if (m_instr == OP_ID) begin
                    for (int i = 0; i < 32; i++) dr_q.push_back(IDV[i]);
                end else if (m_instr == OP_USER) begin
                    for (int i = 0; i < DRW; i++) dr_q.push_back(m_user[i]);
                end else begin
                    dr_q.push_back(1'b0);
                end
            end
            'h2: begin
                m_tdo = dr_q.pop_front();
                dr_q.push_back(d);
            end
            'h5: begin
                if (m_instr == OP_USER) begin
                    for (int i = 0; i < DRW; i++) m_user[i] = dr_q[i];
                    m_upd = 1'b1;
                end
            end
            default: begin
            end
        endcase
        m_state = tap_next(m_state, t);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive inputs at the falling edge, clock once, check all outputs after.
    task automatic applyStimulus(input bit r, input bit t, input bit d);
        @(negedge clk);
        trst = r;
        tms  = t;
        tdi  = d;
        @(posedge clk);
        model_edge(r, t, d);
        #1;
        checkOutput("state_obs", 64'(state_obs), 64'(m_state));
        checkOutput("tdo",       64'(tdo),       64'(m_tdo));
        checkOutput("instr",     64'(instr),     64'(m_instr));
        checkOutput("user_dr",   64'(user_dr),   64'(m_user));
        checkOutput("user_upd",  64'(user_upd),  64'(m_upd));
    endtask

    // IR scan starting and ending in RTI; returns the bits shifted out.
    task automatic scan_ir(input logic [IRW-1:0] val, output logic [IRW-1:0] out);
        out = '0;
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        for (int i = 0; i < IRW; i++) begin
            applyStimulus(0, i == IRW - 1, val[i]);
            out[i] = tdo;
        end
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
    endtask

    // DR scan of n bits from RTI back to RTI, optional pause after bit pause_at.
    task automatic scan_dr(input logic [63:0] val, input int n, input int pause_at,
                           output logic [63:0] out);
        out = '0;
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, (i == n - 1) || (i == pause_at), val[i]);
            out[i] = tdo;
            if (i == pause_at && i != n - 1) begin
                applyStimulus(0, 0, 1'($urandom));
                applyStimulus(0, 0, 1'($urandom));
                applyStimulus(0, 1, 1'($urandom));
                applyStimulus(0, 0, 1'($urandom));
            end
        end
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
    endtask

    task automatic to_rti();
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1'($urandom));
        applyStimulus(0, 0, 0);
    endtask

    initial begin
        logic [IRW-1:0] cap;
        logic [63:0]    w;
        logic [3:0]     byp_ops [2];
        logic [IRW-1:0] op;
        int             n;

        byp_ops[0] = 4'b1111;
        byp_ops[1] = 4'b0111;

        // Reset and first step
        applyStimulus(1, 1, 0);
        checkOutput("rst_state", 64'(state_obs), 64'hF);
        checkOutput("rst_instr", 64'(instr),     64'(OP_ID));
        checkOutput("rst_user",  64'(user_dr),   64'h0);
        checkOutput("rst_tdo",   64'(tdo),       64'h0);
        checkOutput("rst_upd",   64'(user_upd),  64'h0);
        applyStimulus(0, 0, 0);
        checkOutput("rti_state", 64'(state_obs), 64'hC);

        // IDCODE read
        scan_dr(64'h0, 32, -1, w);
        checkOutput("idcode", 64'(w[31:0]), 64'(IDV));
        checkOutput("idcode_noupd", 64'(user_upd), 64'h0);

        // IR load of USER opcode
        scan_ir(OP_USER, cap);
        checkOutput("ir_capture", 64'(cap),   64'h1);
        checkOutput("ir_instr",   64'(instr), 64'(OP_USER));

        // USER write with a pause break, then readback
        scan_dr(64'hA5, DRW, 3, w);
        checkOutput("user_write", 64'(user_dr),  64'hA5);
        checkOutput("user_upd_hi", 64'(user_upd), 64'h1);
        applyStimulus(0, 0, 0);
        checkOutput("user_upd_lo", 64'(user_upd), 64'h0);
        scan_dr(64'h3C, DRW, -1, w);
        checkOutput("user_readback", 64'(w[7:0]), 64'hA5);
        checkOutput("user_rewrite",  64'(user_dr), 64'h3C);

        // Bypass with all-ones and an unknown opcode
        for (int k = 0; k < 2; k++) begin
            scan_ir(byp_ops[k], cap);
            checkOutput("bypass_instr", 64'(instr), 64'(byp_ops[k]));
            scan_dr(64'b1101, 4, -1, w);
            checkOutput("bypass_tdo", 64'(w[3:0]), 64'b1010);
            checkOutput("bypass_noupd", 64'(user_upd), 64'h0);
        end

        // Abort from ShDR with five TMS=1 edges
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0);
        checkOutput("abort_state", 64'(state_obs), 64'hF);
        checkOutput("abort_user",  64'(user_dr),   64'h3C);
        applyStimulus(0, 1, 0);
        checkOutput("abort_instr", 64'(instr), 64'(OP_ID));

        // Reset in the middle of a USER scan
        applyStimulus(0, 0, 0);
        scan_ir(OP_USER, cap);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1);
        applyStimulus(1, 0, 0);
        checkOutput("trst_state", 64'(state_obs), 64'hF);
        checkOutput("trst_user",  64'(user_dr),   64'h0);
        checkOutput("trst_upd",   64'(user_upd),  64'h0);
        applyStimulus(0, 1, 0);
        checkOutput("trst_upd2",  64'(user_upd),  64'h0);

        // Randomized mix against the model
        to_rti();
        for (int it = 0; it < 80; it++) begin
            case ($urandom % 4)
                0: begin
                    case ($urandom % 4)
                        0:       op = OP_ID;
                        1:       op = OP_USER;
                        2:       op = '1;
                        default: op = IRW'($urandom);
                    endcase
                    scan_ir(op, cap);
                    checkOutput("rand_ir_capture", 64'(cap), 64'h1);
                end
                1: begin
                    n = $urandom_range(1, 40);
                    w = {$urandom, $urandom};
                    scan_dr(w, n, ($urandom % 2) ? $urandom_range(0, n - 1) : -1, w);
                end
                2: begin
                    for (int i = 0; i < 25; i++)
                        applyStimulus(($urandom % 50) == 0, ($urandom % 5) < 2, 1'($urandom));
                    to_rti();
                end
                default: begin
                    applyStimulus(1, 1'($urandom), 1'($urandom));
                    applyStimulus(0, 0, 0);
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
